// File: rtl/xor_pipe_frame.sv
// Registered XOR with valid/ready handshake, per-word and per-frame parity.
// Optional frame counter port: define XOR_PIPE_FRAME_STATS_EN.
module xor_pipe_frame #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int PAR_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par,
  output logic             frame_last,
  output logic             frame_par
`ifdef XOR_PIPE_FRAME_STATS_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int CW = $clog2(FRAME_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic POL = (PAR_ODD != 0);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_par_q, y_par_d;
  logic             last_q, last_d;
  logic             fpar_q, fpar_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;

  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] w;
  logic             w_par;

  assign out_valid  = (state_q == FULL);
  assign in_ready   = rst_n & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;
  assign w          = a ^ b;
  assign w_par      = ^w;

  assign y          = y_q;
  assign y_par      = y_par_q;
  assign frame_last = last_q;
  assign frame_par  = fpar_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    y_par_d = y_par_q;
    last_d  = last_q;
    fpar_d  = fpar_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (drain && !accept) state_d = EMPTY;
    endcase
    if (accept) begin
      y_d     = w;
      y_par_d = w_par ^ POL;
      if (cnt_q == CNT_LAST) begin
        last_d = 1'b1;
        fpar_d = acc_q ^ w_par ^ POL;
        cnt_d  = '0;
        acc_d  = 1'b0;
      end else begin
        last_d = 1'b0;
        fpar_d = 1'b0;
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_q ^ w_par;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      y_par_q <= 1'b0;
      last_q  <= 1'b0;
      fpar_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_par_q <= y_par_d;
      last_q  <= last_d;
      fpar_q  <= fpar_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

`ifdef XOR_PIPE_FRAME_STATS_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Counts frames as they leave, saturating rather than wrapping
  always_comb begin
    fcnt_d = fcnt_q;
    if (drain && last_q && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_xor_pipe_frame.sv
// Scoreboard bench for xor_pipe_frame: three parameter sets share one
// stimulus stream; a frame-list reference model predicts every output word.
module tb_xor_pipe_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [2:0] ir, ov, yp, fl, fp;
  logic [7:0] y0, y1;
  logic [0:0] y2;
`ifdef XOR_PIPE_FRAME_STATS_EN
  logic [15:0] fc0, fc1, fc2;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       yp;
    logic       fl;
    logic       fp;
  } exp_t;

  exp_t       sq[3][$];
  logic [7:0] fr[3][$];
  int cfg_w[3]   = '{8, 8, 1};
  int cfg_fl[3]  = '{4, 1, 3};
  int cfg_odd[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  xor_pipe_frame #(.WIDTH(8), .FRAME_LEN(4), .PAR_ODD(0)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready),
    .y(y0), .y_par(yp[0]),
    .frame_last(fl[0]), .frame_par(fp[0])
`ifdef XOR_PIPE_FRAME_STATS_EN
    , .frame_cnt(fc0)
`endif
  );

  xor_pipe_frame #(.WIDTH(8), .FRAME_LEN(1), .PAR_ODD(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready),
    .y(y1), .y_par(yp[1]),
    .frame_last(fl[1]), .frame_par(fp[1])
`ifdef XOR_PIPE_FRAME_STATS_EN
    , .frame_cnt(fc1)
`endif
  );

  xor_pipe_frame #(.WIDTH(1), .FRAME_LEN(3), .PAR_ODD(0)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[2]),
    .a(a[0:0]), .b(b[0:0]),
    .out_valid(ov[2]), .out_ready(out_ready),
    .y(y2), .y_par(yp[2]),
    .frame_last(fl[2]), .frame_par(fp[2])
`ifdef XOR_PIPE_FRAME_STATS_EN
    , .frame_cnt(fc2)
`endif
  );

  function automatic logic [7:0] ycur(input int i);
    if (i == 0) return y0;
    if (i == 1) return y1;
    return {7'b0, y2};
  endfunction

`ifdef XOR_PIPE_FRAME_STATS_EN
  function automatic logic [15:0] fccur(input int i);
    if (i == 0) return fc0;
    if (i == 1) return fc1;
    return fc2;
  endfunction
`endif

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
               nm, i, $time, got, exp);
    end
  endtask

  // Reference: word = a^b cut to WIDTH; a frame closes after FRAME_LEN
  // words and its parity is that of the XOR of all its words.
  function automatic void model_push(input logic [7:0] av,
                                     input logic [7:0] bv);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] w;
      logic [7:0] fx;
      logic       odd;
      exp_t       e;
      odd = (cfg_odd[i] != 0);
      w = av ^ bv;
      if (cfg_w[i] == 1) w = w & 8'h01;
      e.y  = w;
      e.yp = (^w) ^ odd;
      fr[i].push_back(w);
      if (fr[i].size() == cfg_fl[i]) begin
        fx = '0;
        for (int k = 0; k < fr[i].size(); k++) fx = fx ^ fr[i][k];
        e.fl = 1'b1;
        e.fp = (^fx) ^ odd;
        fr[i].delete();
      end else begin
        e.fl = 1'b0;
        e.fp = 1'b0;
      end
      sq[i].push_back(e);
    end
  endfunction

  task automatic step(input logic rst, input logic iv,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic orv, output logic acc);
    @(posedge clk);
    #1;
    rst_n = rst;
    in_valid = iv;
    a = av;
    b = bv;
    out_ready = orv;
    @(negedge clk);
    acc = iv && ir[0];
    if (acc) model_push(av, bv);
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1, 1, av, bv, 1, acc);
    if (!acc) chk("send_timeout", 0, 0, 1);
  endtask

  task automatic do_reset();
    logic acc;
    step(0, 1, 8'h5A, 8'hA5, 1, acc);
    step(0, 1, 8'h5A, 8'hA5, 1, acc);
    for (int i = 0; i < 3; i++) fr[i].delete();
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", i, 32'(ir[i]), 0);
      chk("rst_out_valid", i, 32'(ov[i]), 0);
      chk("rst_y", i, 32'(ycur(i)), 0);
      chk("rst_frame_last", i, 32'(fl[i]), 0);
      chk("rst_frame_par", i, 32'(fp[i]), 0);
    end
  endtask

  // Monitor: handshake rules, latency, stall stability, scoreboard pops
  initial begin
    logic       acc_prev;
    logic [2:0] stall_prev;
    exp_t       held[3];
    exp_t       cur;
    exp_t       e;
    int         efc[3];
    acc_prev = 1'b0;
    stall_prev = '0;
    for (int i = 0; i < 3; i++) efc[i] = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cur = '{y: ycur(i), yp: yp[i], fl: fl[i], fp: fp[i]};
        chk("in_ready_rule", i, 32'(ir[i]),
            32'(rst_n & (~ov[i] | out_ready)));
        if (acc_prev) chk("latency", i, 32'(ov[i]), 1);
        if (stall_prev[i] && ov[i])
          chk("stall_hold", i, 32'(cur), 32'(held[i]));
        if (ov[i] && out_ready) begin
          if (sq[i].size() == 0) begin
            chk("unexpected_out", i, 1, 0);
          end else begin
            e = sq[i].pop_front();
            chk("y", i, 32'(cur.y), 32'(e.y));
            chk("y_par", i, 32'(cur.yp), 32'(e.yp));
            chk("frame_last", i, 32'(cur.fl), 32'(e.fl));
            chk("frame_par", i, 32'(cur.fp), 32'(e.fp));
          end
        end
`ifdef XOR_PIPE_FRAME_STATS_EN
        chk("frame_cnt", i, 32'(fccur(i)), 32'(efc[i]));
        if (!rst_n) efc[i] = 0;
        else if (ov[i] && out_ready && fl[i] && efc[i] < 65535)
          efc[i]++;
`endif
        stall_prev[i] = ov[i] && !out_ready && rst_n;
        held[i] = cur;
        if (!rst_n) sq[i].delete();
      end
      acc_prev = in_valid && ir[0];
    end
  end

  initial begin
    logic acc;
    do_reset();

    // truth table on the 1-bit lane, also one full frame of dut0
    send(8'h00, 8'h00);
    send(8'h00, 8'h01);
    send(8'h01, 8'h00);
    send(8'h01, 8'h01);

    // y = 01,03,07,0F then a fifth word opening a new frame
    send(8'h01, 8'h00);
    send(8'h03, 8'h00);
    send(8'h07, 8'h00);
    send(8'h0F, 8'h00);
    send(8'h1F, 8'h00);

    send(8'hFF, 8'h00);
    send(8'hF0, 8'hF0);

    // back-pressure: stall three cycles, then drain and load together
    step(1, 0, 8'h00, 8'h00, 1, acc);
    step(1, 1, 8'h11, 8'h22, 0, acc);
    chk("bp_fill", 0, 32'(acc), 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 8'h33, 8'h44, 0, acc);
      chk("bp_blocked", 0, 32'(acc), 0);
    end
    step(1, 1, 8'h33, 8'h44, 1, acc);
    chk("bp_pass", 0, 32'(acc), 1);
    step(1, 0, 8'h00, 8'h00, 1, acc);

    for (int k = 0; k < 400; k++)
      step(1, ($urandom % 4) != 0, 8'($urandom), 8'($urandom),
           ($urandom % 3) != 0, acc);

    // reset two words into a frame of dut0
    step(1, 0, 8'h00, 8'h00, 1, acc);
    for (int k = 0; k < 8 && fr[0].size() != 2; k++)
      send(8'($urandom), 8'($urandom));
    chk("mid_frame_pos", 0, 32'(fr[0].size()), 2);
    step(1, 0, 8'h00, 8'h00, 1, acc);
    do_reset();
    for (int k = 0; k < 4; k++) send(8'($urandom), 8'($urandom));
    step(1, 0, 8'h00, 8'h00, 1, acc);
    step(1, 0, 8'h00, 8'h00, 1, acc);

    for (int i = 0; i < 3; i++)
      chk("sb_empty", i, 32'(sq[i].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
